// File: rtl/mult_div_pkg.sv
// Shared types, widths and helpers for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER   = DATA_W;
    localparam int unsigned XW     = DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(ITER);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV_CHK,
        ST_DIV,
        ST_FIX,
        ST_DONE_M,
        ST_DONE_D,
        ST_DZERO
    } state_e;

    // Magnitude of a value that is negative when sign is set; one extra bit holds |most-negative|.
    function automatic logic [XW-1:0] abs_ext(input logic [DATA_W-1:0] value, input logic sign);
        logic [XW-1:0] ext;
        ext = {sign, value};
        return sign ? (~ext + XW'(1)) : ext;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import mult_div_pkg::*;
(
    input  logic [XW-1:0]     i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [XW-1:0]     i_dvs,
    output logic [XW-1:0]     o_rem_c,
    output logic [DATA_W-1:0] o_quo_c
);

    logic [XW:0] w_sh;
    logic        w_ge;

    always_comb begin
        w_sh    = {i_rem, i_quo[DATA_W-1]};
        w_ge    = (w_sh >= {1'b0, i_dvs});
        o_rem_c = w_ge ? XW'(w_sh - {1'b0, i_dvs}) : w_sh[XW-1:0];
        o_quo_c = {i_quo[DATA_W-2:0], w_ge};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// Optional MULT_DIV_UNSIGNED_EN adds op_unsigned for multu/divu.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_ctrl,
    input  logic              div_ctrl,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic              op_unsigned,
`endif
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              mult_out,
    output logic              div_out,
    output logic              div_zero,
    output logic              busy
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_armed;
    logic                w_armed_nxt;
    logic                w_accept;
    logic                w_last;
    logic                w_mult_out_nxt;
    logic                w_div_out_nxt;
    logic                w_div_zero_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [XW-1:0]       r_m;
    logic [XW-1:0]       r_phi;
    logic [DATA_W-1:0]   r_plo;
    logic                r_q1;
    logic [XW-1:0]       r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [XW-1:0]       r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_mult_out;
    logic                r_div_out;
    logic                r_div_zero;
    logic                r_busy;

    logic                w_uns;
    logic                w_uns_in;
    logic                w_sa;
    logic                w_sb;
    logic [XW:0]         w_pext;
    logic [XW:0]         w_mext;
    logic [XW:0]         w_bsum;
    logic [2*DATA_W-1:0] w_prod;
    logic [XW-1:0]       w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W-1:0]   w_q_fix;
    logic [DATA_W-1:0]   w_r_fix;

`ifdef MULT_DIV_UNSIGNED_EN
    logic r_uns;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uns <= 1'b0;
        end else if (w_accept) begin
            r_uns <= op_unsigned;
        end
    end

    assign w_uns    = r_uns;
    assign w_uns_in = op_unsigned;
`else
    assign w_uns    = 1'b0;
    assign w_uns_in = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(ITER - 1));
    assign w_sa   = !w_uns && r_a[DATA_W-1];
    assign w_sb   = !w_uns && r_b[DATA_W-1];

    // Next-state and done-pulse decode; armed blocks restart while the request is still held.
    always_comb begin
        w_state_nxt    = r_state;
        w_armed_nxt    = r_armed;
        w_accept       = 1'b0;
        w_mult_out_nxt = 1'b0;
        w_div_out_nxt  = 1'b0;
        w_div_zero_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!mult_ctrl && !div_ctrl) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_accept    = 1'b1;
                    w_armed_nxt = 1'b0;
                    w_state_nxt = mult_ctrl ? ST_MULT : ST_DIV_CHK;
                end
            end
            ST_MULT:    if (w_last) w_state_nxt = ST_DONE_M;
            ST_DONE_M: begin
                w_mult_out_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            ST_DIV_CHK: w_state_nxt = (r_b == '0) ? ST_DZERO : ST_DIV;
            ST_DZERO: begin
                w_div_zero_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            ST_DIV:     if (w_last) w_state_nxt = ST_FIX;
            ST_FIX:     w_state_nxt = ST_DONE_D;
            ST_DONE_D: begin
                w_div_out_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_mult_out <= 1'b0;
            r_div_out  <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= w_armed_nxt;
            r_mult_out <= w_mult_out_nxt;
            r_div_out  <= w_div_out_nxt;
            r_div_zero <= w_div_zero_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Booth step on {P_hi, P_lo, q-1}; sum carries an extra bit so the arithmetic shift is exact.
    always_comb begin
        w_pext = {r_phi[XW-1], r_phi};
        w_mext = {r_m[XW-1], r_m};
        case ({r_plo[0], r_q1})
            2'b01:   w_bsum = w_pext + w_mext;
            2'b10:   w_bsum = w_pext - w_mext;
            default: w_bsum = w_pext;
        endcase
    end

    // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set needs +M<<W.
    assign w_prod = {r_phi[DATA_W-1:0], r_plo}
                  + ((w_uns && r_b[DATA_W-1]) ? {r_m[DATA_W-1:0], {DATA_W{1'b0}}}
                                               : {(2*DATA_W){1'b0}});

    div_step u_div_step (
        .i_rem   (r_rem),
        .i_quo   (r_quo),
        .i_dvs   (r_dvs),
        .o_rem_c (w_rem_nxt),
        .o_quo_c (w_quo_nxt)
    );

    assign w_q_fix = r_neg_q ? (~r_quo + DATA_W'(1)) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem[DATA_W-1:0] + DATA_W'(1)) : r_rem[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_q1    <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_m   <= w_uns_in ? {1'b0, a} : {a[DATA_W-1], a};
                        r_phi <= '0;
                        r_plo <= b;
                        r_q1  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_MULT: begin
                    r_phi <= w_bsum[XW:1];
                    r_plo <= {w_bsum[0], r_plo[DATA_W-1:1]};
                    r_q1  <= r_plo[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_DONE_M: begin
                    r_hi <= w_prod[2*DATA_W-1:DATA_W];
                    r_lo <= w_prod[DATA_W-1:0];
                end
                ST_DIV_CHK: begin
                    if (r_b != '0) begin
                        r_rem   <= '0;
                        r_quo   <= DATA_W'(abs_ext(r_a, w_sa));
                        r_dvs   <= abs_ext(r_b, w_sb);
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_cnt   <= '0;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    r_quo <= w_q_fix;
                    r_rem <= {1'b0, w_r_fix};
                end
                ST_DONE_D: begin
                    r_hi <= r_rem[DATA_W-1:0];
                    r_lo <= r_quo;
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mult_out = r_mult_out;
    assign div_out  = r_div_out;
    assign div_zero = r_div_zero;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard queue, reset-abort and re-arm sequence.
module tb_mult_div_unit;

    typedef struct {
        bit          do_mult;
        bit          do_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [2:0]  kind;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_ctrl = 1'b0;
    logic        div_ctrl = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_out;
    logic        div_out;
    logic        div_zero;
    logic        busy;
`ifdef MULT_DIV_UNSIGNED_EN
    logic        op_unsigned = 1'b0;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[16];

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mult_ctrl (mult_ctrl),
        .div_ctrl  (div_ctrl),
`ifdef MULT_DIV_UNSIGNED_EN
        .op_unsigned (op_unsigned),
`endif
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .mult_out  (mult_out),
        .div_out   (div_out),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input bit is_div, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, p, q, r;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        if (!is_div) begin
            p  = sa * sb;
            mh = p[63:32];
            ml = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            mh = r[31:0];
            ml = q[31:0];
        end
    endfunction

    // Drive one request, push its expectation, then wait (bounded) for a done pulse and score it.
    task automatic run_op(input bit do_mult, input bit do_div, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        exp_t e;
        int   c;
        bit   seen;
        @(negedge clk);
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        @(negedge clk);
        a         = va;
        b         = vb;
        mult_ctrl = do_mult;
        div_ctrl  = do_div;
        e.hi = ehi;
        e.lo = elo;
        if (do_mult) begin
            e.kind = 3'b100; e.lat = 33;
        end else if (vb == 32'd0) begin
            e.kind = 3'b001; e.lat = 2;
        end else begin
            e.kind = 3'b010; e.lat = 35;
        end
        sb_q.push_back(e);
        @(negedge clk);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 80) begin
            @(negedge clk);
            c++;
            if (c == 1) chk({tag, "_busy"}, 64'(busy), 64'(1));
            if (c == 3) begin
                a = ~va;
                b = ~vb;
            end
            if (mult_out || div_out || div_zero) seen = 1'b1;
        end
        e = sb_q.pop_front();
        chk({tag, "_lat"}, 64'(c), 64'(e.lat));
        chk({tag, "_kind"}, 64'({mult_out, div_out, div_zero}), 64'(e.kind));
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        @(negedge clk);
        chk({tag, "_after"}, 64'({mult_out, div_out, div_zero, busy}), 64'(0));
        chk({tag, "_hold"}, {hi, lo}, {e.hi, e.lo});
    endtask

    initial begin
        logic [31:0] ra, rb, mh, ml;
        bit          is_div;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[3]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{1'b1, 1'b1, 32'd6,        32'd4,        32'd0,        32'd24};
        vecs[7]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[10] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'd1};
        vecs[11] = '{1'b0, 1'b1, 32'd3,        32'd10,       32'd3,        32'd0};
        vecs[12] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'd0,        32'hC0000000};
        vecs[13] = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
        vecs[14] = '{1'b0, 1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h80000000};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0};

        repeat (3) @(negedge clk);
        chk("reset_state", {hi, lo, 28'(0), mult_out, div_out, div_zero, busy}, 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset", {hi, lo, 28'(0), mult_out, div_out, div_zero, busy}, 64'(0));

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].do_mult, vecs[i].do_div, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            is_div = 1'($urandom_range(0, 1));
            ra     = $urandom;
            rb     = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (is_div && rb == 32'd0) rb = 32'd1;
            model(is_div, ra, rb, mh, ml);
            run_op(!is_div, is_div, ra, rb, mh, ml, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a multiply: immediate clear, no pulse, no restart until ctrl drops.
        @(negedge clk);
        mult_ctrl = 1'b0;
        div_ctrl  = 1'b0;
        @(negedge clk);
        a         = 32'd3;
        b         = 32'd5;
        mult_ctrl = 1'b1;
        repeat (11) @(negedge clk);
        chk("rst_mid_busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        chk("rst_mid_clear", {hi, lo}, 64'(0));
        chk("rst_mid_flags", 64'({mult_out, div_out, div_zero, busy}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", i), 64'({mult_out, div_out, div_zero, busy}), 64'(0));
        end
        run_op(1'b1, 1'b0, 32'd6, 32'd4, 32'd0, 32'd24, "rearm");

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
